// File: rtl/mdom_scdb_hdr_assembler_pkg.sv
// mdom_scdb_hdr_assembler_pkg
//   Field widths and bit offsets of the 113-bit per-channel SCDB header
//   bundle. The assembler (fan-in) and the readout fan-out both import this
//   package, so both sides always agree on the layout.
//   No ports; constants and types only.
package mdom_scdb_hdr_assembler_pkg;

  // Field widths
  localparam int LTC_W  = 49;
  localparam int ADDR_W = 12;
  localparam int SRC_W  = 2;
  localparam int PRE_W  = 5;
  localparam int BSUM_W = 19;
  localparam int BLEN_W = 3;
  localparam int CHAN_W = 5;
  localparam int HDR_W  = 113;

  // Field LSB positions, LSB first
  localparam int LTC_LSB     = 0;
  localparam int START_LSB   = 49;
  localparam int STOP_LSB    = 61;
  localparam int SRC_LSB     = 73;
  localparam int CNST_BIT    = 75;
  localparam int PRE_LSB     = 76;
  localparam int SYNC_BIT    = 81;
  localparam int BSUM_LSB    = 82;
  localparam int BLEN_LSB    = 101;
  localparam int BVALID_BIT  = 104;
  localparam int LCOINC_BIT  = 105;
  localparam int PARTIAL_BIT = 106;
  localparam int CONT_BIT    = 107;
  localparam int CHAN_LSB    = 108;

  // Capture FSM states
  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_OPEN = 1'b1
  } cap_state_e;

  // Trigger-time fields held while a waveform is open
  typedef struct packed {
    logic [LTC_W-1:0]  evt_ltc;
    logic [ADDR_W-1:0] start_addr;
    logic [SRC_W-1:0]  trig_src;
    logic              cnst_run;
    logic [PRE_W-1:0]  pre_conf;
    logic              sync_rdy;
    logic [BSUM_W-1:0] bsum;
    logic [BLEN_W-1:0] bsum_len_sel;
    logic              bsum_valid;
    logic              local_coinc;
    logic [CHAN_W-1:0] channel_idx;
  } trig_fields_t;

endpackage

// File: rtl/mdom_scdb_hdr_bundle_fan_in.sv
// mdom_scdb_hdr_bundle_fan_in
//   Purely combinational packer: places the trigger-time fields and the
//   end-of-waveform fields at their package-defined offsets in the header.
// Ports:
//   trig          in   trigger-time fields (struct)
//   stop_addr     in   waveform buffer stop address
//   partial_wfm   in   waveform truncated
//   continued_wfm in   waveform continues a previous one
//   hdr           out  packed 113-bit header
module mdom_scdb_hdr_bundle_fan_in
  import mdom_scdb_hdr_assembler_pkg::*;
(
  input  trig_fields_t      trig,
  input  logic [ADDR_W-1:0] stop_addr,
  input  logic              partial_wfm,
  input  logic              continued_wfm,
  output logic [HDR_W-1:0]  hdr
);

  // Every bit of the layout is covered by exactly one field; the default
  // only guards against a future layout with gaps.
  always_comb begin
    hdr = '0;
    hdr[LTC_LSB   +: LTC_W]  = trig.evt_ltc;
    hdr[START_LSB +: ADDR_W] = trig.start_addr;
    hdr[STOP_LSB  +: ADDR_W] = stop_addr;
    hdr[SRC_LSB   +: SRC_W]  = trig.trig_src;
    hdr[CNST_BIT]            = trig.cnst_run;
    hdr[PRE_LSB   +: PRE_W]  = trig.pre_conf;
    hdr[SYNC_BIT]            = trig.sync_rdy;
    hdr[BSUM_LSB  +: BSUM_W] = trig.bsum;
    hdr[BLEN_LSB  +: BLEN_W] = trig.bsum_len_sel;
    hdr[BVALID_BIT]          = trig.bsum_valid;
    hdr[LCOINC_BIT]          = trig.local_coinc;
    hdr[PARTIAL_BIT]         = partial_wfm;
    hdr[CONT_BIT]            = continued_wfm;
    hdr[CHAN_LSB  +: CHAN_W] = trig.channel_idx;
  end

endmodule

// File: rtl/mdom_scdb_hdr_assembler.sv
// mdom_scdb_hdr_assembler
//   Builds the per-channel SCDB header: trigger-time fields are latched when
//   a trigger is accepted, end-of-waveform fields are merged when the
//   waveform closes, and the packed header is offered to the header FIFO
//   through a one-entry valid/ready output register. Headers that arrive
//   while the output is occupied and not draining are dropped and counted.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   en                   block enable (0 returns to IDLE, discards open header)
//   trig_start           trigger accepted pulse + trigger-time fields
//   evt_ltc .. channel_idx
//   wfm_done             waveform closed pulse + stop_addr/partial/continued
//   hdr_bundle/hdr_valid header output, hdr_ready from FIFO
//   hdr_drop             one-cycle pulse per lost header
//   drop_cnt             saturating count of lost headers
//   seq_err              sticky protocol violation flag
module mdom_scdb_hdr_assembler
  import mdom_scdb_hdr_assembler_pkg::*;
#(
  parameter int DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  trig_start,
  input  logic [LTC_W-1:0]      evt_ltc,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [SRC_W-1:0]      trig_src,
  input  logic                  cnst_run,
  input  logic [PRE_W-1:0]      pre_conf,
  input  logic                  sync_rdy,
  input  logic [BSUM_W-1:0]     bsum,
  input  logic [BLEN_W-1:0]     bsum_len_sel,
  input  logic                  bsum_valid,
  input  logic                  local_coinc,
  input  logic [CHAN_W-1:0]     channel_idx,
  input  logic                  wfm_done,
  input  logic [ADDR_W-1:0]     stop_addr,
  input  logic                  partial_wfm,
  input  logic                  continued_wfm,
  output logic [HDR_W-1:0]      hdr_bundle,
  output logic                  hdr_valid,
  input  logic                  hdr_ready,
  output logic                  hdr_drop,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic                  seq_err
);

  localparam logic [DROP_CNT_W-1:0] CNT_ONE = DROP_CNT_W'(1);

  cap_state_e   state_q, state_d;
  trig_fields_t open_q;
  trig_fields_t trig_now;
  logic         capture;
  logic         form_hdr;
  logic         seq_viol;
  logic         load_hdr;
  logic         drop_hdr;
  logic [HDR_W-1:0] formed_hdr;

  assign trig_now = '{
    evt_ltc:      evt_ltc,
    start_addr:   start_addr,
    trig_src:     trig_src,
    cnst_run:     cnst_run,
    pre_conf:     pre_conf,
    sync_rdy:     sync_rdy,
    bsum:         bsum,
    bsum_len_sel: bsum_len_sel,
    bsum_valid:   bsum_valid,
    local_coinc:  local_coinc,
    channel_idx:  channel_idx
  };

  // Capture FSM decisions. A simultaneous trig_start & wfm_done while OPEN
  // closes the current header and reopens with the new trigger in one clk,
  // which is how back-to-back continued waveforms arrive. With en low
  // nothing is captured, formed or flagged, and the FSM falls back to IDLE.
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    form_hdr = 1'b0;
    seq_viol = 1'b0;
    if (!en) begin
      state_d = CAP_IDLE;
    end else begin
      case (state_q)
        CAP_IDLE: begin
          if (trig_start) begin
            capture = 1'b1;
            state_d = CAP_OPEN;
          end
          if (wfm_done) begin
            seq_viol = 1'b1;
          end
        end
        CAP_OPEN: begin
          if (wfm_done) begin
            form_hdr = 1'b1;
            if (trig_start) begin
              capture = 1'b1;
            end else begin
              state_d = CAP_IDLE;
            end
          end else if (trig_start) begin
            seq_viol = 1'b1;
          end
        end
        default: state_d = CAP_IDLE;
      endcase
    end
  end

  // State register and open-header field register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CAP_IDLE;
      open_q  <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        open_q <= trig_now;
      end
    end
  end

  mdom_scdb_hdr_bundle_fan_in u_fan_in (
    .trig          (open_q),
    .stop_addr     (stop_addr),
    .partial_wfm   (partial_wfm),
    .continued_wfm (continued_wfm),
    .hdr           (formed_hdr)
  );

  // The single output slot accepts a new header when empty or when its
  // current content is leaving this cycle; otherwise the new one is lost.
  assign load_hdr = form_hdr & (~hdr_valid | hdr_ready);
  assign drop_hdr = form_hdr & hdr_valid & ~hdr_ready;

  // Output register, drop reporting and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_bundle <= '0;
      hdr_valid  <= 1'b0;
      hdr_drop   <= 1'b0;
      drop_cnt   <= '0;
      seq_err    <= 1'b0;
    end else begin
      if (load_hdr) begin
        hdr_bundle <= formed_hdr;
        hdr_valid  <= 1'b1;
      end else if (hdr_valid && hdr_ready) begin
        hdr_valid <= 1'b0;
      end
      hdr_drop <= drop_hdr;
      if (drop_hdr && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_ONE;
      end
      if (seq_viol) begin
        seq_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mdom_scdb_hdr_assembler.sv
// tb_mdom_scdb_hdr_assembler
//   Directed and randomized checks of the header assembler against a
//   record-level model: the model tracks "is a waveform open", the captured
//   trigger record, and the one-entry output slot, and builds expected
//   headers by concatenating fields in layout order. A second instance with
//   a 4-bit drop counter shares all inputs to exercise saturation.
module tb_mdom_scdb_hdr_assembler;

  logic         clk = 1'b0;
  logic         rst, en, trig_start, wfm_done, hdr_ready;
  logic [48:0]  evt_ltc;
  logic [11:0]  start_addr, stop_addr;
  logic [1:0]   trig_src;
  logic         cnst_run, sync_rdy, bsum_valid, local_coinc;
  logic         partial_wfm, continued_wfm;
  logic [4:0]   pre_conf, channel_idx;
  logic [18:0]  bsum;
  logic [2:0]   bsum_len_sel;

  logic [112:0] hdr_bundle, s_hdr_bundle;
  logic         hdr_valid, s_hdr_valid, hdr_drop, s_hdr_drop, seq_err, s_seq_err;
  logic [15:0]  drop_cnt;
  logic [3:0]   s_drop_cnt;

  int checks = 0;
  int errors = 0;

  // Clock generation, 10 time-unit period
  always #5 clk = ~clk;

  mdom_scdb_hdr_assembler #(.DROP_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .trig_start(trig_start),
    .evt_ltc(evt_ltc), .start_addr(start_addr), .trig_src(trig_src),
    .cnst_run(cnst_run), .pre_conf(pre_conf), .sync_rdy(sync_rdy),
    .bsum(bsum), .bsum_len_sel(bsum_len_sel), .bsum_valid(bsum_valid),
    .local_coinc(local_coinc), .channel_idx(channel_idx),
    .wfm_done(wfm_done), .stop_addr(stop_addr), .partial_wfm(partial_wfm),
    .continued_wfm(continued_wfm), .hdr_bundle(hdr_bundle),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_drop(hdr_drop),
    .drop_cnt(drop_cnt), .seq_err(seq_err)
  );

  mdom_scdb_hdr_assembler #(.DROP_CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .trig_start(trig_start),
    .evt_ltc(evt_ltc), .start_addr(start_addr), .trig_src(trig_src),
    .cnst_run(cnst_run), .pre_conf(pre_conf), .sync_rdy(sync_rdy),
    .bsum(bsum), .bsum_len_sel(bsum_len_sel), .bsum_valid(bsum_valid),
    .local_coinc(local_coinc), .channel_idx(channel_idx),
    .wfm_done(wfm_done), .stop_addr(stop_addr), .partial_wfm(partial_wfm),
    .continued_wfm(continued_wfm), .hdr_bundle(s_hdr_bundle),
    .hdr_valid(s_hdr_valid), .hdr_ready(hdr_ready), .hdr_drop(s_hdr_drop),
    .drop_cnt(s_drop_cnt), .seq_err(s_seq_err)
  );

  // Reference model state
  typedef struct {
    logic [48:0] ltc;
    logic [11:0] start;
    logic [1:0]  src;
    logic        cnst;
    logic [4:0]  pre;
    logic        sync;
    logic [18:0] bsum;
    logic [2:0]  bls;
    logic        bv;
    logic        lc;
    logic [4:0]  chan;
  } trig_rec_t;

  trig_rec_t    m_rec;
  bit           m_open;
  logic         m_valid;
  logic [112:0] m_bundle;
  logic         m_drop;
  int           m_drops;
  logic         m_seq;

  function automatic logic [112:0] packHeader(trig_rec_t t, logic [11:0] stop,
                                              logic part, logic cont);
    return {t.chan, cont, part, t.lc, t.bv, t.bls, t.bsum, t.sync, t.pre,
            t.cnst, t.src, stop, t.start, t.ltc};
  endfunction

  function automatic trig_rec_t sampleTrig();
    trig_rec_t t;
    t.ltc = evt_ltc; t.start = start_addr; t.src = trig_src; t.cnst = cnst_run;
    t.pre = pre_conf; t.sync = sync_rdy; t.bsum = bsum; t.bls = bsum_len_sel;
    t.bv = bsum_valid; t.lc = local_coinc; t.chan = channel_idx;
    return t;
  endfunction

  // One clock of the model, applied with the inputs present at the edge
  task automatic modelStep();
    bit form, viol;
    form = en && m_open && wfm_done;
    viol = en && ((!m_open && wfm_done) || (m_open && trig_start && !wfm_done));
    if (rst) begin
      m_open = 0; m_valid = 0; m_bundle = '0; m_drop = 0; m_drops = 0; m_seq = 0;
    end else begin
      if (form && (!m_valid || hdr_ready)) begin
        m_bundle = packHeader(m_rec, stop_addr, partial_wfm, continued_wfm);
        m_valid  = 1;
        m_drop   = 0;
      end else if (form) begin
        m_drop  = 1;
        m_drops = m_drops + 1;
      end else begin
        if (m_valid && hdr_ready) m_valid = 0;
        m_drop = 0;
      end
      if (!en) m_open = 0;
      else if (trig_start && (!m_open || wfm_done)) begin
        m_rec  = sampleTrig();
        m_open = 1;
      end else if (m_open && wfm_done) m_open = 0;
      if (viol) m_seq = 1;
    end
  endtask

  task automatic checkOne(string tag, logic [112:0] obs, logic [112:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    int exp_main, exp_sat;
    exp_main = (m_drops > 65535) ? 65535 : m_drops;
    exp_sat  = (m_drops > 15) ? 15 : m_drops;
    checkOne("hdr_valid", 113'(hdr_valid), 113'(m_valid));
    checkOne("hdr_bundle", hdr_bundle, m_bundle);
    checkOne("hdr_drop", 113'(hdr_drop), 113'(m_drop));
    checkOne("drop_cnt", 113'(drop_cnt), 113'(exp_main));
    checkOne("seq_err", 113'(seq_err), 113'(m_seq));
    checkOne("sat_hdr_valid", 113'(s_hdr_valid), 113'(m_valid));
    checkOne("sat_hdr_bundle", s_hdr_bundle, m_bundle);
    checkOne("sat_hdr_drop", 113'(s_hdr_drop), 113'(m_drop));
    checkOne("sat_drop_cnt", 113'(s_drop_cnt), 113'(exp_sat));
    checkOne("sat_seq_err", 113'(s_seq_err), 113'(m_seq));
  endtask

  task automatic randomizeFields();
    logic [63:0] r64;
    r64 = {$urandom, $urandom};
    evt_ltc = r64[48:0];
    start_addr = 12'($urandom); stop_addr = 12'($urandom);
    trig_src = 2'($urandom); cnst_run = 1'($urandom); pre_conf = 5'($urandom);
    sync_rdy = 1'($urandom); bsum = 19'($urandom); bsum_len_sel = 3'($urandom);
    bsum_valid = 1'($urandom); local_coinc = 1'($urandom);
    channel_idx = 5'($urandom); partial_wfm = 1'($urandom);
    continued_wfm = 1'($urandom);
  endtask

  // Drive one cycle of control inputs, advance the model, check all outputs
  task automatic applyStimulus(input logic r, input logic e, input logic ts,
                               input logic wd, input logic rdy);
    rst = r; en = e; trig_start = ts; wfm_done = wd; hdr_ready = rdy;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  logic [112:0] held;

  initial begin
    m_open = 0; m_valid = 0; m_bundle = '0; m_drop = 0; m_drops = 0; m_seq = 0;
    m_rec = '{default: '0};
    randomizeFields();

    // Reset state
    applyStimulus(1, 1, 0, 0, 1);
    applyStimulus(1, 1, 1, 1, 1);

    // Single event
    randomizeFields();
    evt_ltc = 49'h1_2345_6789_ABCD; start_addr = 12'h010;
    channel_idx = 5'd7; bsum = 19'h4_0001;
    applyStimulus(0, 1, 1, 0, 1);
    randomizeFields();
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 1);
    stop_addr = 12'h0FF; partial_wfm = 1'b1;
    applyStimulus(0, 1, 0, 1, 1);
    checkOne("single_valid", 113'(hdr_valid), 113'(1));
    checkOne("single_ltc", 113'(hdr_bundle[48:0]), 113'(49'h1_2345_6789_ABCD));
    checkOne("single_start", 113'(hdr_bundle[60:49]), 113'(12'h010));
    checkOne("single_stop", 113'(hdr_bundle[72:61]), 113'(12'h0FF));
    checkOne("single_bsum", 113'(hdr_bundle[100:82]), 113'(19'h4_0001));
    checkOne("single_partial", 113'(hdr_bundle[106]), 113'(1));
    checkOne("single_chan", 113'(hdr_bundle[112:108]), 113'(5'd7));
    randomizeFields();
    applyStimulus(0, 1, 0, 0, 1);
    checkOne("single_valid_clear", 113'(hdr_valid), 113'(0));

    // Backpressure: second header is dropped, first held stable
    randomizeFields(); applyStimulus(0, 1, 1, 0, 0);
    randomizeFields(); applyStimulus(0, 1, 0, 1, 0);
    held = hdr_bundle;
    randomizeFields(); applyStimulus(0, 1, 1, 0, 0);
    randomizeFields(); applyStimulus(0, 1, 0, 1, 0);
    checkOne("bp_drop_pulse", 113'(hdr_drop), 113'(1));
    checkOne("bp_drop_cnt", 113'(drop_cnt), 113'(1));
    checkOne("bp_held", hdr_bundle, held);
    randomizeFields(); applyStimulus(0, 1, 0, 0, 1);
    checkOne("bp_no_drop", 113'(hdr_drop), 113'(0));
    randomizeFields(); applyStimulus(0, 1, 0, 0, 1);
    checkOne("bp_drained", 113'(hdr_valid), 113'(0));

    // Same-cycle close/open
    randomizeFields(); evt_ltc = 49'h0_00AA_BBCC_DDEE;
    applyStimulus(0, 1, 1, 0, 1);
    randomizeFields(); evt_ltc = 49'd100;
    applyStimulus(0, 1, 1, 1, 1);
    checkOne("b2b_old_ltc", 113'(hdr_bundle[48:0]), 113'(49'h0_00AA_BBCC_DDEE));
    randomizeFields(); applyStimulus(0, 1, 0, 1, 1);
    checkOne("b2b_new_ltc", 113'(hdr_bundle[48:0]), 113'(49'd100));
    checkOne("b2b_no_seq_err", 113'(seq_err), 113'(0));

    // Protocol errors
    randomizeFields(); applyStimulus(0, 1, 0, 0, 1);
    randomizeFields(); applyStimulus(0, 1, 0, 1, 1);
    checkOne("idle_wfm_no_valid", 113'(hdr_valid), 113'(0));
    checkOne("idle_wfm_seq_err", 113'(seq_err), 113'(1));
    randomizeFields(); evt_ltc = 49'h0_0000_0000_1111;
    applyStimulus(0, 1, 1, 0, 1);
    randomizeFields(); evt_ltc = 49'h0_0000_0000_2222;
    applyStimulus(0, 1, 1, 0, 1);
    randomizeFields(); applyStimulus(0, 1, 0, 1, 1);
    checkOne("open_trig_keeps_ltc", 113'(hdr_bundle[48:0]), 113'(49'h1111));

    // Saturation of the 4-bit counter
    applyStimulus(1, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      randomizeFields(); applyStimulus(0, 1, 1, 0, 0);
      randomizeFields(); applyStimulus(0, 1, 0, 1, 0);
    end
    checkOne("sat_cnt_ff", 113'(s_drop_cnt), 113'(4'hF));
    checkOne("main_cnt_19", 113'(drop_cnt), 113'(19));

    // Reset while OPEN with a valid header pending
    randomizeFields(); applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    checkOne("rst_valid", 113'(hdr_valid), 113'(0));
    checkOne("rst_cnt", 113'(drop_cnt), 113'(0));
    checkOne("rst_seq", 113'(seq_err), 113'(0));
    randomizeFields(); applyStimulus(0, 1, 0, 1, 0);
    checkOne("rst_then_wfm_seq", 113'(seq_err), 113'(1));

    // Enable dropped while OPEN discards the open header
    randomizeFields(); applyStimulus(0, 1, 1, 0, 1);
    randomizeFields(); applyStimulus(0, 0, 0, 0, 1);
    randomizeFields(); applyStimulus(0, 1, 0, 1, 1);
    checkOne("en_discard", 113'(hdr_valid), 113'(0));

    // Randomized traffic
    applyStimulus(1, 1, 0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      randomizeFields();
      applyStimulus(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 19) != 0),
                    1'($urandom), 1'($urandom),
                    ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdom_scdb_hdr_assembler.md
Name: mdom_scdb_hdr_assembler

Overview:
- Builds the 113-bit per-channel SCDB header bundle from the per-channel trigger and waveform-writer events.
- Captures the trigger-time fields when the trigger is accepted and the end-of-waveform fields when the waveform closes.
- Presents the packed bundle to the header FIFO with a valid/ready handshake.
- Sits between the channel trigger/waveform writer and the header FIFO; the fan-out on the readout side consumes the same layout.

Parameters:
- DROP_CNT_W, 16, width of the saturating dropped-header counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- en  in  1  block enable; 0 forces IDLE and blocks new captures
- trig_start  in  1  pulse: trigger accepted; capture trigger-time fields
- evt_ltc  in  49  local time count at trigger
- start_addr  in  12  waveform buffer start address
- trig_src  in  2  trigger source code
- cnst_run  in  1  constant-run flag
- pre_conf  in  5  pretrigger configuration
- sync_rdy  in  1  LTC sync-ready status
- bsum  in  19  baseline sum
- bsum_len_sel  in  3  baseline length select
- bsum_valid  in  1  baseline sum valid
- local_coinc  in  1  local coincidence flag
- channel_idx  in  5  channel index
- wfm_done  in  1  pulse: waveform closed; capture end fields and emit header
- stop_addr  in  12  waveform buffer stop address
- partial_wfm  in  1  waveform truncated
- continued_wfm  in  1  waveform continues a previous one
- hdr_bundle  out  113  packed header
- hdr_valid  out  1  hdr_bundle valid
- hdr_ready  in  1  FIFO can accept
- hdr_drop  out  1  one-cycle pulse: header lost because the output was occupied
- drop_cnt  out  DROP_CNT_W  saturating count of dropped headers
- seq_err  out  1  sticky: protocol violation seen; cleared only by rst

Behaviour:
- Bundle layout, LSB first:
  - evt_ltc [48:0]
  - start_addr [60:49]
  - stop_addr [72:61]
  - trig_src [74:73]
  - cnst_run [75]
  - pre_conf [80:76]
  - sync_rdy [81]
  - bsum [100:82]
  - bsum_len_sel [103:101]
  - bsum_valid [104]
  - local_coinc [105]
  - partial_wfm [106]
  - continued_wfm [107]
  - channel_idx [112:108]
- Reset values: all outputs 0, including hdr_bundle, drop_cnt and seq_err. Capture state is IDLE.
- Capture FSM, two states:
  - IDLE, trig_start & en: latch all trigger-time fields into the open register; go to OPEN.
  - IDLE, wfm_done: ignored; seq_err <= 1.
  - OPEN, wfm_done alone: form the header from the open fields plus stop_addr/partial_wfm/continued_wfm sampled that cycle; go to IDLE.
  - OPEN, trig_start without wfm_done: ignored, open fields keep their values; seq_err <= 1.
  - OPEN, trig_start & wfm_done in the same cycle: close the current header as above, and latch the new trigger fields in the same cycle; stay OPEN. This is back-to-back continued waveforms and is not an error.
- en = 0: FSM returns to IDLE next cycle and the open header is discarded without counting. The output register is unaffected.
- Output register, one entry, skid-free:
  - Transfer occurs when hdr_valid & hdr_ready.
  - A formed header is loaded when !hdr_valid or a transfer happens this cycle. hdr_valid = 1 and hdr_bundle are registered the cycle after wfm_done, so latency is 1 clk.
  - Otherwise the header is dropped: hdr_drop pulses in the cycle after wfm_done, and drop_cnt increments, saturating at all-ones.
- Output rules:
  - hdr_bundle is stable while hdr_valid & !hdr_ready.
  - hdr_valid clears the cycle after a transfer unless a new header loads.
- rst mid-operation: synchronous; it discards both the open and output entries and clears counters on the next edge.
- Throughput: one header per clk when hdr_ready stays high.

Decomposition:
- Shared package holds the field width and offset constants (LTC_W=49, ADDR_W=12, BSUM_W=19, CHAN_W=5, HDR_W=113 and each field LSB). The fan-out side uses the same package.
- One sub-module is natural: mdom_scdb_hdr_bundle_fan_in, a purely combinational packer built from the package offsets. The assembler instantiates it on the output-register input.

Test Plan:
- Single event: trig_start with evt_ltc=49'h1_2345_6789_ABCD, start_addr=12'h010, channel_idx=5'd7, bsum=19'h4_0001; three cycles later wfm_done with stop_addr=12'h0FF, partial_wfm=1; hdr_ready=1 -> next cycle hdr_valid=1 and the fields decode at the layout offsets ([72:61]=12'h0FF, [106]=1, [112:108]=7); hdr_valid=0 the cycle after.
- Backpressure: hdr_ready=0, two complete events -> first header held stable, second gives hdr_drop pulse and drop_cnt=1. Raise hdr_ready -> first header transfers, no further drop.
- Same-cycle close/open: OPEN, then trig_start & wfm_done together with new evt_ltc=100 -> header carries the old evt_ltc; the next wfm_done yields a header with evt_ltc=100; seq_err stays 0.
- Protocol errors: wfm_done in IDLE -> no hdr_valid, seq_err=1. trig_start in OPEN -> header keeps the first evt_ltc.
- Saturation: DROP_CNT_W=4, hdr_ready=0, 20 events -> drop_cnt stays at 4'hF.
- Reset/enable mid-operation: rst asserted while OPEN with hdr_valid=1 -> next cycle hdr_valid=0, drop_cnt=0, seq_err=0, and a later wfm_done sets seq_err. en=0 while OPEN -> the following wfm_done produces no header.
